fx_fir_serial_mac: RTL and testbench
====================================

Name: fx_fir_serial_mac

Overview:
Parametrised, time-multiplexed sign-magnitude fixed-point FIR filter for the band-filter chain. It is the successor to the fixed 30-tap, 10-bit, hard-coded-coefficient filters. One shared multiplier-accumulator processes one tap per clock. Coefficients are run-time loadable. Input uses a valid/ready handshake, and the output saturates instead of wrapping.

Parameters:
DW, 10, sample width; sign-magnitude, MSB = sign, DW-1 fractional magnitude bits.
CW, 10, coefficient width; sign-magnitude, same format.
TAPS, 30, filter length; must be at least 2.
AW, $clog2(TAPS), width of the coefficient and sample addresses.
GW, $clog2(TAPS), accumulator guard bits.

Ports:
clk_slow  in  1  sample-domain clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-low reset.
coef_wr_en  in  1  coefficient write strobe.
coef_wr_addr  in  AW  tap index k, valid range 0..TAPS-1.
coef_wr_data  in  CW  sign-magnitude coefficient h[k].
in_valid  in  1  fir_in holds a sample.
in_ready  out  1  block can accept a sample.
fir_in  in  DW  sign-magnitude sample x[n].
out_valid  out  1  one-cycle pulse; fir_out is new.
fir_out  out  DW  sign-magnitude y[n]; held until the next result.
sat  out  1  y[n] was clipped; updated together with fir_out.
busy  out  1  high in MAC and DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All coefficient and sample-buffer entries, head pointer, tap counter and accumulator clear to 0.
  - fir_out=0, sat=0, out_valid=0, busy=0, in_ready=0 while rst is low.
  - Reset during MAC or DONE abandons the sample; no out_valid is produced.
- FSM transitions:
  - IDLE: in_ready=1. If in_valid=1, store fir_in at buf[head], clear the accumulator, set k=0 and go to MAC.
  - MAC: lasts exactly TAPS cycles. Each cycle adds h[k] * buf[(head-k) mod TAPS] to the accumulator, then k increments. After k=TAPS-1, go to DONE.
  - DONE: register fir_out and sat, pulse out_valid=1 for one cycle, advance head (TAPS-1 wraps to 0), return to IDLE.
- Latency: sample accepted on edge E0 gives out_valid=1 in the cycle after edge E0+TAPS+1. Maximum throughput is one sample per TAPS+2 cycles.
- in_ready=0 in MAC and DONE. in_valid is ignored there, and fir_in may change freely. A sample held valid is accepted on the first IDLE cycle.
- There is no output backpressure; out_valid is a single pulse.
- Coefficient writes take effect only in IDLE, where the new h[k] is used by the next accepted sample.
  - In MAC or DONE the write is dropped silently.
  - coef_wr_addr >= TAPS is ignored.
  - A coefficient write and a sample accept in the same IDLE cycle are both performed; the sample uses the new coefficient.
- Arithmetic:
  - Convert operands from sign-magnitude to two's complement. Negative zero counts as 0.
  - Product width is DW+CW-1; accumulator width is DW+CW-1+GW, two's complement.
  - In DONE, take mag = |acc| >> (CW-1), which truncates toward zero.
  - If mag > 2^(DW-1)-1: fir_out = {sign, all ones}, sat=1.
  - Otherwise: fir_out = {sign, mag[DW-2:0]}, sat=0.
  - A zero result always has sign 0 (negative zero is never emitted).
- Sample history is circular: x[n-k] for k beyond the samples received since reset reads 0.

Test Plan:
All tests use defaults DW=CW=10, TAPS=30.
1. Reset defaults: after reset with no coefficient writes, feed fir_in=10'b0111111111 -> out_valid exactly 31 cycles after the accept edge, fir_out=0, sat=0; in_ready low for 31 cycles.
2. Impulse response: load h[k]=k+2 (positive), feed 10'b0100000000 then 29 zeros -> the i-th output (i=0..29) has fir_out=(i+2)>>1, with sign 0.
3. Sign handling: h[0]=10'b0100000000, other taps 0. Input 10'b1100000000 -> fir_out=10'b1010000000. Input 10'b1000000000 (negative zero) -> fir_out=10'b0000000000.
4. Saturation: all h=10'b0111111111, 30 samples of 10'b0111111111 -> final fir_out=10'b0111111111, sat=1. Repeat with 10'b1111111111 samples -> fir_out=10'b1111111111, sat=1.
5. Handshake and coefficient lockout: hold in_valid=1 continuously -> accepts spaced 32 cycles apart. A coefficient write to h[0] issued during MAC -> the next output is unchanged versus the golden model.
6. Mid-operation reset: assert rst at MAC cycle 10 -> no out_valid. After release, the first sample's output equals the single-sample golden value with an empty history.

Source files
------------

// File: rtl/fx_fir_serial_mac.sv
// Time-multiplexed sign-magnitude FIR: one shared MAC evaluates one tap per clock,
// with run-time loadable coefficients, valid/ready input and saturating output.
module fx_fir_serial_mac #(
  parameter int DW   = 10,
  parameter int CW   = 10,
  parameter int TAPS = 30,
  parameter int AW   = $clog2(TAPS),
  parameter int GW   = $clog2(TAPS)
) (
  input  logic          clk_slow,
  input  logic          rst,
  input  logic          coef_wr_en,
  input  logic [AW-1:0] coef_wr_addr,
  input  logic [CW-1:0] coef_wr_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] fir_in,
  output logic          out_valid,
  output logic [DW-1:0] fir_out,
  output logic          sat,
  output logic          busy
);

  localparam int PW   = DW + CW - 1;
  localparam int ACCW = PW + GW;
  localparam logic [AW:0]     TAPS_W  = (AW+1)'(TAPS);
  localparam logic [AW-1:0]   LAST_K  = AW'(TAPS - 1);
  localparam logic [ACCW-1:0] MAX_MAG = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  logic [CW-1:0]          coef_r [TAPS];
  logic [DW-1:0]          hist_r [TAPS];
  logic [AW-1:0]          head_r;
  logic [AW-1:0]          k_r;
  logic signed [ACCW-1:0] acc_r;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic [DW-1:0]          fir_out_r;
  logic                   sat_r;
  logic                   busy_r;

  logic                   accept_s;
  logic                   last_tap_s;
  logic                   coef_wr_ok_s;
  logic [AW:0]            idx_sum_s;
  logic [AW-1:0]          idx_s;
  logic signed [PW-1:0]   x_tc_s;
  logic signed [PW-1:0]   h_tc_s;
  logic signed [PW-1:0]   prod_s;
  logic                   acc_neg_s;
  logic [ACCW-1:0]        acc_abs_s;
  logic [ACCW-1:0]        mag_s;
  logic                   ovf_s;
  logic [DW-1:0]          result_s;

  // Negative zero maps to plain zero because the negated magnitude is zero.
  function automatic logic signed [PW-1:0] data_to_tc(input logic [DW-1:0] v);
    logic signed [PW-1:0] mag;
    mag = signed'(PW'(v[DW-2:0]));
    return v[DW-1] ? -mag : mag;
  endfunction

  function automatic logic signed [PW-1:0] coef_to_tc(input logic [CW-1:0] v);
    logic signed [PW-1:0] mag;
    mag = signed'(PW'(v[CW-2:0]));
    return v[CW-1] ? -mag : mag;
  endfunction

  assign accept_s     = in_ready_r & in_valid;
  assign last_tap_s   = (k_r == LAST_K);
  assign coef_wr_ok_s = coef_wr_en & (state_r == IDLE) & ({1'b0, coef_wr_addr} < TAPS_W);
  assign idx_sum_s    = {1'b0, head_r} + TAPS_W - {1'b0, k_r};

  // Circular history index (head - k) mod TAPS.
  always_comb begin
    idx_s = idx_sum_s[AW-1:0];
    if (idx_sum_s >= TAPS_W) begin
      idx_s = AW'(idx_sum_s - TAPS_W);
    end else begin
      idx_s = idx_sum_s[AW-1:0];
    end
  end

  assign x_tc_s = data_to_tc(hist_r[idx_s]);
  assign h_tc_s = coef_to_tc(coef_r[k_r]);
  assign prod_s = x_tc_s * h_tc_s;

  // Rescale the accumulator back to sample format, truncating toward zero.
  always_comb begin
    acc_neg_s = acc_r[ACCW-1];
    acc_abs_s = acc_neg_s ? unsigned'(-acc_r) : unsigned'(acc_r);
    mag_s     = acc_abs_s >> (CW - 1);
    ovf_s     = (mag_s > MAX_MAG);
    if (ovf_s) begin
      result_s = {acc_neg_s, {(DW-1){1'b1}}};
    end else begin
      result_s = {acc_neg_s & (|mag_s), mag_s[DW-2:0]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = MAC;
        end else begin
          state_next_s = IDLE;
        end
      end
      MAC: begin
        if (last_tap_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = MAC;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Coefficient store, sample history, tap counter and accumulator.
  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_r[i] <= {CW{1'b0}};
        hist_r[i] <= {DW{1'b0}};
      end
      head_r <= {AW{1'b0}};
      k_r    <= {AW{1'b0}};
      acc_r  <= {ACCW{1'b0}};
    end else begin
      if (coef_wr_ok_s) begin
        coef_r[coef_wr_addr] <= coef_wr_data;
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            hist_r[head_r] <= fir_in;
            acc_r          <= {ACCW{1'b0}};
            k_r            <= {AW{1'b0}};
          end
        end
        MAC: begin
          acc_r <= acc_r + ACCW'(prod_s);
          k_r   <= last_tap_s ? {AW{1'b0}} : k_r + AW'(1'b1);
        end
        DONE: begin
          head_r <= (head_r == LAST_K) ? {AW{1'b0}} : head_r + AW'(1'b1);
        end
        default: begin
          k_r <= {AW{1'b0}};
        end
      endcase
    end
  end

  // Registered handshake, status and result outputs.
  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      fir_out_r   <= {DW{1'b0}};
      sat_r       <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == IDLE);
      busy_r      <= (state_next_s != IDLE);
      out_valid_r <= (state_r == DONE);
      if (state_r == DONE) begin
        fir_out_r <= result_s;
        sat_r     <= ovf_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign fir_out   = fir_out_r;
  assign sat       = sat_r;

endmodule

// File: tb/tb_fx_fir_serial_mac.sv
// Self-checking bench for fx_fir_serial_mac: directed and random samples compared
// against a convolution model built from coefficient and history arrays.
module tb_fx_fir_serial_mac;

  localparam int DW   = 10;
  localparam int CW   = 10;
  localparam int TAPS = 30;

  logic          clk_slow = 1'b0;
  logic          rst = 1'b0;
  logic          coef_wr_en = 1'b0;
  logic [4:0]    coef_wr_addr = 5'd0;
  logic [CW-1:0] coef_wr_data = 10'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] fir_in = 10'd0;
  logic          out_valid;
  logic [DW-1:0] fir_out;
  logic          sat;
  logic          busy;

  fx_fir_serial_mac #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
    .clk_slow    (clk_slow),
    .rst         (rst),
    .coef_wr_en  (coef_wr_en),
    .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .fir_in      (fir_in),
    .out_valid   (out_valid),
    .fir_out     (fir_out),
    .sat         (sat),
    .busy        (busy)
  );

  always #5 clk_slow = ~clk_slow;

  int unsigned cyc = 0;
  always @(posedge clk_slow) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;
  bit mid_wr = 1'b0;

  logic [CW-1:0] mcoef [TAPS];
  logic [DW-1:0] mhist [$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int sm_val(input logic [9:0] v);
    int m;
    m = int'(v[8:0]);
    return v[9] ? -m : m;
  endfunction

  task automatic model_expect(output logic [9:0] fo, output logic s);
    int acc;
    int mag;
    bit neg;
    acc = 0;
    for (int k = 0; k < TAPS; k++) begin
      if (k < mhist.size()) acc += sm_val(mcoef[k]) * sm_val(mhist[k]);
    end
    neg = (acc < 0);
    mag = (neg ? -acc : acc) / 512;
    if (mag > 511) begin
      fo = {neg, 9'h1FF};
      s  = 1'b1;
    end else begin
      fo = {neg && (mag != 0), mag[8:0]};
      s  = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_slow);
    @(negedge clk_slow);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    coef_wr_en = 1'b0;
    repeat (3) @(negedge clk_slow);
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_fir_out", fir_out, 32'd0);
    check("rst_sat", sat, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < TAPS; k++) mcoef[k] = 10'd0;
    mhist.delete();
    @(negedge clk_slow);
  endtask

  task automatic wr_coef(input int k, input logic [9:0] v);
    coef_wr_en = 1'b1;
    coef_wr_addr = k[4:0];
    coef_wr_data = v;
    tick();
    coef_wr_en = 1'b0;
    if (k < TAPS) mcoef[k] = v;
  endtask

  task automatic run_sample(input logic [9:0] x, input bit hold, input bit wr, input int wa,
                            input logic [9:0] wd, output int unsigned acc_cyc);
    int g;
    int lat;
    bit rdy_low;
    logic [9:0] efo;
    logic es;
    g = 0;
    lat = 0;
    rdy_low = 1'b1;
    while (!in_ready && g < 200) begin
      tick();
      g++;
    end
    check("ready_wait", in_ready, 32'd1);
    in_valid = 1'b1;
    fir_in = x;
    if (wr) begin
      coef_wr_en = 1'b1;
      coef_wr_addr = wa[4:0];
      coef_wr_data = wd;
    end
    tick();
    acc_cyc = cyc;
    in_valid = hold;
    fir_in = 10'($urandom);
    coef_wr_en = 1'b0;
    if (wr && wa < TAPS) mcoef[wa] = wd;
    mhist.push_front(x);
    if (mhist.size() > TAPS) void'(mhist.pop_back());
    model_expect(efo, es);
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      if (mid_wr && lat == 5) begin
        coef_wr_en = 1'b1;
        coef_wr_addr = 5'd0;
        coef_wr_data = 10'($urandom);
      end else begin
        coef_wr_en = 1'b0;
      end
      tick();
      lat++;
    end
    coef_wr_en = 1'b0;
    check("latency", lat, 32'd31);
    check("ready_low_in_mac", rdy_low, 32'd1);
    check("fir_out", fir_out, {22'd0, efo});
    check("sat", sat, {31'd0, es});
    check("busy_idle", busy, 32'd0);
    if (!hold) begin
      tick();
      check("pulse_single", out_valid, 32'd0);
    end
  endtask

  initial begin
    int unsigned a_cyc;
    int unsigned prev_cyc;
    logic [9:0] rv;
    logic [9:0] saved [TAPS];
    bit seen;

    // 1: defaults after reset
    do_reset();
    run_sample(10'b0111111111, 1'b0, 1'b0, 0, 10'd0, a_cyc);
    check("t1_zero_out", fir_out, 32'd0);

    // 2: impulse response
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(k, 10'(k + 2));
    for (int i = 0; i < TAPS; i++) begin
      run_sample((i == 0) ? 10'b0100000000 : 10'd0, 1'b0, 1'b0, 0, 10'd0, a_cyc);
      check("t2_impulse", fir_out, 32'((i + 2) >> 1));
    end

    // 3: sign handling and negative zero
    do_reset();
    wr_coef(0, 10'b0100000000);
    run_sample(10'b1100000000, 1'b0, 1'b0, 0, 10'd0, a_cyc);
    check("t3_negative", fir_out, 32'b1010000000);
    run_sample(10'b1000000000, 1'b0, 1'b0, 0, 10'd0, a_cyc);
    check("t3_neg_zero", fir_out, 32'd0);

    // 4: saturation both polarities
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(k, 10'b0111111111);
    for (int i = 0; i < TAPS; i++) run_sample(10'b0111111111, 1'b0, 1'b0, 0, 10'd0, a_cyc);
    check("t4_pos_sat_out", fir_out, 32'b0111111111);
    check("t4_pos_sat", sat, 32'd1);
    for (int i = 0; i < TAPS; i++) run_sample(10'b1111111111, 1'b0, 1'b0, 0, 10'd0, a_cyc);
    check("t4_neg_sat_out", fir_out, 32'b1111111111);
    check("t4_neg_sat", sat, 32'd1);

    // 5: held in_valid, same-cycle write, MAC-time write lockout, bad address
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(k, 10'($urandom));
    wr_coef(30, 10'($urandom));
    wr_coef(31, 10'($urandom));
    run_sample(10'($urandom), 1'b1, 1'b1, 3, 10'($urandom), prev_cyc);
    mid_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_sample(10'($urandom), 1'b1, 1'b0, 0, 10'd0, a_cyc);
      check("t5_spacing", a_cyc - prev_cyc, 32'd32);
      prev_cyc = a_cyc;
    end
    in_valid = 1'b0;
    mid_wr = 1'b0;
    for (int i = 0; i < 4; i++) run_sample(10'($urandom), 1'b0, 1'b0, 0, 10'd0, a_cyc);

    // 6: reset in the middle of MAC
    do_reset();
    for (int k = 0; k < TAPS; k++) begin
      rv = 10'($urandom);
      saved[k] = rv;
      wr_coef(k, rv);
    end
    while (!in_ready) tick();
    in_valid = 1'b1;
    fir_in = 10'($urandom);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    check("t6_busy_mac", busy, 32'd1);
    rst = 1'b0;
    #1;
    check("t6_async_busy", busy, 32'd0);
    check("t6_async_ready", in_ready, 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("t6_no_out_valid", seen, 32'd0);
    for (int k = 0; k < TAPS; k++) mcoef[k] = 10'd0;
    mhist.delete();
    for (int k = 0; k < TAPS; k++) wr_coef(k, saved[k]);
    run_sample(10'($urandom), 1'b0, 1'b0, 0, 10'd0, a_cyc);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
